lcd_field_regs: RTL

Register front-end that sits directly upstream of lcd_display. It owns the two 64-bit hex fields (16 nibbles per LCD line) and the two 16-bit digit masks that drive the display.
- A Wishbone-classic slave writes shadow copies of the fields and masks.
- A commit mechanism copies the shadow copies atomically into the live outputs, so the LCD never shows a half-updated line.
- A free-running blink generator can blank selected digits periodically.

---
 rtl/lcd_field_regs_if.sv | 21 ++
 rtl/lcd_field_regs.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lcd_field_regs_if.sv
// Wishbone-classic slave bus for the LCD field register block.
// Master drives address/data/strobe; slave returns registered data and ack.
interface lcd_field_regs_if;
   logic [3:0]  wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/lcd_field_regs.sv
// Shadow/live register front-end for lcd_display: Wishbone writes go to shadow
// copies, an atomic commit publishes them, and a blink generator masks digits.
module lcd_field_regs #(
   parameter int BLINK_DIV = 24
) (
   input  logic             clk,
   input  logic             rst,
   lcd_field_regs_if.slave  wb,
   output logic [63:0]      f1,
   output logic [63:0]      f2,
   output logic [15:0]      m1,
   output logic [15:0]      m2,
   output logic             blink_phase
);

   logic [7:0][15:0]      sh_f_q, sh_f_d;
   logic [15:0]           sh_m1_q, sh_m1_d;
   logic [15:0]           sh_m2_q, sh_m2_d;
   logic [15:0]           ben1_q, ben1_d;
   logic [15:0]           ben2_q, ben2_d;
   logic                  auto_q, auto_d;
   logic                  freeze_q, freeze_d;
   logic                  creq_q, creq_d;
   logic [63:0]           live_f1_q, live_f1_d;
   logic [63:0]           live_f2_q, live_f2_d;
   logic [15:0]           live_m1_q, live_m1_d;
   logic [15:0]           live_m2_q, live_m2_d;
   logic [15:0]           m1_q, m1_d;
   logic [15:0]           m2_q, m2_d;
   logic [BLINK_DIV-1:0]  cnt_q, cnt_d;
   logic                  phase_q, phase_d;
   logic                  ack_q, ack_d;
   logic [15:0]           dat_q, dat_d;

   logic                  acc;
   logic                  wr;
   logic                  commit_go;
   logic [15:0]           rd_dat;

   always_comb begin
      acc       = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
      wr        = acc & wb.wb_we_i;
      commit_go = creq_q & ~freeze_q;

      rd_dat = 16'h0000;
      case (wb.wb_adr_i)
         4'd0, 4'd1, 4'd2, 4'd3,
         4'd4, 4'd5, 4'd6, 4'd7: rd_dat = sh_f_q[wb.wb_adr_i[2:0]];
         4'd8:                   rd_dat = sh_m1_q;
         4'd9:                   rd_dat = sh_m2_q;
         4'd10:                  rd_dat = ben1_q;
         4'd11:                  rd_dat = ben2_q;
         4'd12:                  rd_dat = {13'h0000, freeze_q, auto_q, 1'b0};
         4'd13:                  rd_dat = {14'h0000, phase_q, creq_q};
         default:                rd_dat = 16'h0000;
      endcase

      sh_f_d    = sh_f_q;
      sh_m1_d   = sh_m1_q;
      sh_m2_d   = sh_m2_q;
      ben1_d    = ben1_q;
      ben2_d    = ben2_q;
      auto_d    = auto_q;
      freeze_d  = freeze_q;
      creq_d    = creq_q;
      live_f1_d = live_f1_q;
      live_f2_d = live_f2_q;
      live_m1_d = live_m1_q;
      live_m2_d = live_m2_q;

      // Commit samples the pre-write shadows; a same-edge write may re-arm it below.
      if (commit_go) begin
         live_f1_d = sh_f_q[3:0];
         live_f2_d = sh_f_q[7:4];
         live_m1_d = sh_m1_q;
         live_m2_d = sh_m2_q;
         creq_d    = 1'b0;
      end

      if (wr) begin
         case (wb.wb_adr_i)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: sh_f_d[wb.wb_adr_i[2:0]] = wb.wb_dat_i;
            4'd8:                   sh_m1_d = wb.wb_dat_i;
            4'd9:                   sh_m2_d = wb.wb_dat_i;
            4'd10:                  ben1_d  = wb.wb_dat_i;
            4'd11:                  ben2_d  = wb.wb_dat_i;
            4'd12: begin
               auto_d   = wb.wb_dat_i[1];
               freeze_d = wb.wb_dat_i[2];
               if (wb.wb_dat_i[0]) creq_d = 1'b1;
            end
            default: ;
         endcase
         if (auto_q && (wb.wb_adr_i <= 4'd11)) creq_d = 1'b1;
      end

      ack_d = acc;
      dat_d = acc ? rd_dat : dat_q;

      cnt_d   = cnt_q + {{(BLINK_DIV-1){1'b0}}, 1'b1};
      phase_d = phase_q ^ (&cnt_q);

      m1_d = live_m1_q & ~(ben1_q & {16{phase_q}});
      m2_d = live_m2_q & ~(ben2_q & {16{phase_q}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_f_q    <= '0;
         sh_m1_q   <= '0;
         sh_m2_q   <= '0;
         ben1_q    <= '0;
         ben2_q    <= '0;
         auto_q    <= 1'b0;
         freeze_q  <= 1'b0;
         creq_q    <= 1'b0;
         live_f1_q <= '0;
         live_f2_q <= '0;
         live_m1_q <= '0;
         live_m2_q <= '0;
         m1_q      <= '0;
         m2_q      <= '0;
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         sh_f_q    <= sh_f_d;
         sh_m1_q   <= sh_m1_d;
         sh_m2_q   <= sh_m2_d;
         ben1_q    <= ben1_d;
         ben2_q    <= ben2_d;
         auto_q    <= auto_d;
         freeze_q  <= freeze_d;
         creq_q    <= creq_d;
         live_f1_q <= live_f1_d;
         live_f2_q <= live_f2_d;
         live_m1_q <= live_m1_d;
         live_m2_q <= live_m2_d;
         m1_q      <= m1_d;
         m2_q      <= m2_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign f1          = live_f1_q;
   assign f2          = live_f2_q;
   assign m1          = m1_q;
   assign m2          = m2_q;
   assign blink_phase = phase_q;

endmodule
